// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I encodings plus the decode-stage control types shared by decoder, bus and execute
package rv32i_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR_LA   = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BYTE    = 3'b000;
  localparam logic [2:0] F3_HALF    = 3'b001;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BYTE_U  = 3'b100;
  localparam logic [2:0] F3_HALF_U  = 3'b101;
  localparam logic [6:0] F7_DEFAULT = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_t;
  typedef enum logic [1:0] {JMP_NONE = 2'b00, JMP_JAL = 2'b01, JMP_JALR = 2'b10} jmp_t;
  typedef struct packed {
    alu_op_t    alu_op;
    logic       src_a;
    logic       src_b;
    logic       br;
    jmp_t       jmp;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] funct3;
    logic       wb_en;
    logic       illegal;
  } id_ex_ctrl_t;
  function automatic alu_op_t alu_of(input logic [2:0] f3, input logic alt);
    return f3 == F3_ADD_SUB ? (alt ? ALU_SUB : ALU_ADD) :
           f3 == F3_SLL     ? ALU_SLL  :
           f3 == F3_SLT     ? ALU_SLT  :
           f3 == F3_SLTU    ? ALU_SLTU :
           f3 == F3_XOR     ? ALU_XOR  :
           f3 == F3_SR_LA   ? (alt ? ALU_SRA : ALU_SRL) :
           f3 == F3_OR      ? ALU_OR   : ALU_AND;
  endfunction
endpackage

// File: rtl/id_decode_stage_if.sv
// id_decode_stage_if: fetch-side and execute-side handshake bundle of the decode stage
interface id_decode_stage_if
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) ();
  logic            flush_i;
  logic            if_valid_i;
  logic            if_ready_o;
  logic [XLEN-1:0] if_pc_i;
  logic [31:0]     if_instr_i;
  logic            ex_valid_o;
  logic            ex_ready_i;
  logic [XLEN-1:0] ex_pc_o;
  logic [4:0]      ex_rs1_o;
  logic [4:0]      ex_rs2_o;
  logic [4:0]      ex_rd_o;
  logic [XLEN-1:0] ex_imm_o;
  alu_op_t         ex_alu_op_o;
  logic            ex_src_a_o;
  logic            ex_src_b_o;
  logic            ex_br_o;
  jmp_t            ex_jmp_o;
  logic            ex_mem_rd_o;
  logic            ex_mem_wr_o;
  logic [2:0]      ex_funct3_o;
  logic            ex_wb_en_o;
  logic            ex_illegal_o;
  modport slave (
    input  flush_i, if_valid_i, if_pc_i, if_instr_i, ex_ready_i,
    output if_ready_o, ex_valid_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_imm_o,
           ex_alu_op_o, ex_src_a_o, ex_src_b_o, ex_br_o, ex_jmp_o, ex_mem_rd_o,
           ex_mem_wr_o, ex_funct3_o, ex_wb_en_o, ex_illegal_o
  );
  modport master (
    output flush_i, if_valid_i, if_pc_i, if_instr_i, ex_ready_i,
    input  if_ready_o, ex_valid_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_imm_o,
           ex_alu_op_o, ex_src_a_o, ex_src_b_o, ex_br_o, ex_jmp_o, ex_mem_rd_o,
           ex_mem_wr_o, ex_funct3_o, ex_wb_en_o, ex_illegal_o
  );
endinterface

// File: rtl/rv32i_imm_gen.sv
// rv32i_imm_gen: sign-extended immediate for the I/S/B/U/J formats, zero otherwise
module rv32i_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);
  assign imm = fmt == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
               fmt == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
               fmt == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
               fmt == IMM_U ? {instr[31:12], 12'b0} :
               fmt == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
               32'b0;
endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: RV32I decode with a single registered valid/ready output stage towards execute
module id_decode_stage
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              rst,
  id_decode_stage_if.slave bus
);
  logic [31:0] instr, imm;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd, rs1_q, rs2_q, rd_q;
  logic wr, ill, valid_q, accept;
  logic [XLEN-1:0] pc_q, imm_q;
  id_ex_ctrl_t ctrl, ctrl_q;
  imm_fmt_t fmt;
  assign instr = bus.if_instr_i;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  always_comb begin
    ctrl = '0;
    fmt = IMM_NONE;
    rs1 = '0;
    rs2 = '0;
    rd = '0;
    wr = 1'b0;
    ill = 1'b0;
    case (opc)
      OP_R_TYPE: begin
        {rs1, rs2, rd, wr, ctrl.funct3} = {instr[19:15], instr[24:20], instr[11:7], 1'b1, f3};
        ctrl.alu_op = alu_of(f3, f7 == F7_ALT);
        ill = f7 != F7_DEFAULT && !(f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SR_LA));
      end
      OP_I_TYPE: begin
        {rs1, rd, wr, ctrl.funct3, ctrl.src_b, fmt} = {instr[19:15], instr[11:7], 1'b1, f3, 1'b1, IMM_I};
        ctrl.alu_op = alu_of(f3, f3 == F3_SR_LA && f7 == F7_ALT);
        ill = (f3 == F3_SLL && f7 != F7_DEFAULT) || (f3 == F3_SR_LA && f7 != F7_DEFAULT && f7 != F7_ALT);
      end
      OP_LOAD: begin
        {rs1, rd, wr, ctrl.funct3, ctrl.src_b, ctrl.mem_rd, fmt} = {instr[19:15], instr[11:7], 1'b1, f3, 2'b11, IMM_I};
        ill = !(f3 inside {F3_BYTE, F3_HALF, F3_WORD, F3_BYTE_U, F3_HALF_U});
      end
      OP_STORE: begin
        {rs1, rs2, ctrl.funct3, ctrl.src_b, ctrl.mem_wr, fmt} = {instr[19:15], instr[24:20], f3, 2'b11, IMM_S};
        ill = !(f3 inside {F3_BYTE, F3_HALF, F3_WORD});
      end
      OP_BRANCH: begin
        {rs1, rs2, ctrl.funct3, ctrl.br, fmt} = {instr[19:15], instr[24:20], f3, 1'b1, IMM_B};
        ill = f3 == 3'b010 || f3 == 3'b011;
      end
      OP_JALR: begin
        {rs1, rd, wr, ctrl.funct3, ctrl.src_b, fmt} = {instr[19:15], instr[11:7], 1'b1, f3, 1'b1, IMM_I};
        ctrl.jmp = JMP_JALR;
        ill = f3 != 3'b000;
      end
      OP_JAL: begin
        {rd, wr, ctrl.src_a, ctrl.src_b, fmt} = {instr[11:7], 3'b111, IMM_J};
        ctrl.jmp = JMP_JAL;
      end
      OP_LUI: begin
        {rd, wr, ctrl.src_b, fmt} = {instr[11:7], 2'b11, IMM_U};
        ctrl.alu_op = ALU_PASS_B;
      end
      OP_AUIPC: {rd, wr, ctrl.src_a, ctrl.src_b, fmt} = {instr[11:7], 3'b111, IMM_U};
      default: ill = 1'b1;
    endcase
    ctrl.wb_en = wr && rd != '0;
    if (ill) begin
      ctrl = '0;
      ctrl.illegal = 1'b1;
      rs1 = '0;
      rs2 = '0;
      rd = '0;
      fmt = IMM_NONE;
    end
  end
  rv32i_imm_gen u_imm (.instr(instr[31:7]), .fmt(fmt), .imm(imm));
  assign bus.if_ready_o = !valid_q || bus.ex_ready_i;
  assign accept = bus.if_valid_i && bus.if_ready_o;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      pc_q <= RESET_PC;
      ctrl_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q <= '0;
      imm_q <= '0;
    end else if (bus.flush_i) valid_q <= 1'b0;
    else if (accept) begin
      valid_q <= 1'b1;
      pc_q <= bus.if_pc_i;
      ctrl_q <= ctrl;
      rs1_q <= rs1;
      rs2_q <= rs2;
      rd_q <= rd;
      imm_q <= imm;
    end else if (bus.ex_ready_i) valid_q <= 1'b0;
  assign bus.ex_valid_o = valid_q;
  assign bus.ex_pc_o = pc_q;
  assign bus.ex_rs1_o = rs1_q;
  assign bus.ex_rs2_o = rs2_q;
  assign bus.ex_rd_o = rd_q;
  assign bus.ex_imm_o = imm_q;
  assign bus.ex_alu_op_o = ctrl_q.alu_op;
  assign bus.ex_src_a_o = ctrl_q.src_a;
  assign bus.ex_src_b_o = ctrl_q.src_b;
  assign bus.ex_br_o = ctrl_q.br;
  assign bus.ex_jmp_o = ctrl_q.jmp;
  assign bus.ex_mem_rd_o = ctrl_q.mem_rd;
  assign bus.ex_mem_wr_o = ctrl_q.mem_wr;
  assign bus.ex_funct3_o = ctrl_q.funct3;
  assign bus.ex_wb_en_o = ctrl_q.wb_en;
  assign bus.ex_illegal_o = ctrl_q.illegal;
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed vector table, handshake corner sequences and a randomized run against a reference decoder
module tb_id_decode_stage;
  import rv32i_pkg::*;
  localparam logic [31:0] RPC = 32'h0000_0080;
  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0] alu;
    logic sa, sb, br;
    logic [1:0] jmp;
    logic mr, mw;
    logic [2:0] f3;
    logic wb, ill;
  } dec_t;
  typedef struct {
    logic [31:0] instr;
    dec_t exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, failures = 0;
  id_decode_stage_if #(.XLEN(32)) bus ();
  id_decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] g, input logic [63:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, g, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic dec_t mk(input logic [4:0] rs1, rs2, rd, input logic [31:0] imm, input logic [3:0] alu,
                              input logic sa, sb, br, input logic [1:0] jmp, input logic mr, mw,
                              input logic [2:0] f3, input logic wb, ill);
    dec_t d;
    d = '{rs1: rs1, rs2: rs2, rd: rd, imm: imm, alu: alu, sa: sa, sb: sb, br: br, jmp: jmp,
          mr: mr, mw: mw, f3: f3, wb: wb, ill: ill};
    return d;
  endfunction
  function automatic dec_t got();
    dec_t d;
    d.rs1 = bus.ex_rs1_o; d.rs2 = bus.ex_rs2_o; d.rd = bus.ex_rd_o; d.imm = bus.ex_imm_o;
    d.alu = bus.ex_alu_op_o; d.sa = bus.ex_src_a_o; d.sb = bus.ex_src_b_o; d.br = bus.ex_br_o;
    d.jmp = bus.ex_jmp_o; d.mr = bus.ex_mem_rd_o; d.mw = bus.ex_mem_wr_o; d.f3 = bus.ex_funct3_o;
    d.wb = bus.ex_wb_en_o; d.ill = bus.ex_illegal_o;
    return d;
  endfunction
  function automatic dec_t ref_dec(input logic [31:0] i);
    dec_t d;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic legal, writes;
    logic [3:0] tab [8];
    d = '0;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    legal = 1'b0;
    writes = 1'b0;
    if (op == 7'h33) begin
      legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.rd = i[11:7]; d.f3 = f3; writes = 1'b1;
      d.alu = f7 == 7'h20 ? (f3 == 3'd0 ? 4'(ALU_SUB) : 4'(ALU_SRA)) : tab[f3];
    end else if (op == 7'h13) begin
      legal = !(f3 == 3'd1 && f7 != 7'h00) && !(f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      d.rs1 = i[19:15]; d.rd = i[11:7]; d.f3 = f3; d.sb = 1'b1; writes = 1'b1;
      d.imm = 32'($signed(i[31:20]));
      d.alu = (f3 == 3'd5 && f7 == 7'h20) ? 4'(ALU_SRA) : tab[f3];
    end else if (op == 7'h03) begin
      legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      d.rs1 = i[19:15]; d.rd = i[11:7]; d.f3 = f3; d.sb = 1'b1; d.mr = 1'b1; writes = 1'b1;
      d.imm = 32'($signed(i[31:20]));
    end else if (op == 7'h23) begin
      legal = f3 <= 3'd2;
      d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.f3 = f3; d.sb = 1'b1; d.mw = 1'b1;
      d.imm = 32'($signed({i[31:25], i[11:7]}));
    end else if (op == 7'h63) begin
      legal = f3 != 3'd2 && f3 != 3'd3;
      d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.f3 = f3; d.br = 1'b1;
      d.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    end else if (op == 7'h67) begin
      legal = f3 == 3'd0;
      d.rs1 = i[19:15]; d.rd = i[11:7]; d.sb = 1'b1; d.jmp = 2'b10; writes = 1'b1;
      d.imm = 32'($signed(i[31:20]));
    end else if (op == 7'h6f) begin
      legal = 1'b1;
      d.rd = i[11:7]; d.sa = 1'b1; d.sb = 1'b1; d.jmp = 2'b01; writes = 1'b1;
      d.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    end else if (op == 7'h37 || op == 7'h17) begin
      legal = 1'b1;
      d.rd = i[11:7]; d.sb = 1'b1; d.sa = op == 7'h17; writes = 1'b1;
      d.imm = {i[31:12], 12'h000};
      d.alu = op == 7'h37 ? 4'(ALU_PASS_B) : 4'(ALU_ADD);
    end
    if (!legal) begin
      d = '0;
      d.ill = 1'b1;
    end else d.wb = writes && d.rd != 5'd0;
    return d;
  endfunction
  initial begin
    vec_t vt[$];
    logic [6:0] ops [10];
    dec_t ha, e_dec;
    logic ev, acc;
    logic [31:0] epc;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6f, 7'h37, 7'h17, 7'h73};
    vt.push_back('{32'h00500093, mk(0, 0, 1, 32'd5, ALU_ADD, 0, 1, 0, 0, 0, 0, 0, 1, 0)});
    vt.push_back('{32'h402081B3, mk(1, 2, 3, 32'd0, ALU_SUB, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vt.push_back('{32'hFFDFF0EF, mk(0, 0, 1, 32'hFFFFFFFC, ALU_ADD, 1, 1, 0, 1, 0, 0, 0, 1, 0)});
    vt.push_back('{32'h00208463, mk(1, 2, 0, 32'd8, ALU_ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0)});
    vt.push_back('{32'h0020A223, mk(1, 2, 0, 32'd4, ALU_ADD, 0, 1, 0, 0, 0, 1, 2, 0, 0)});
    vt.push_back('{32'h00000000, mk(0, 0, 0, 32'd0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
    vt.push_back('{32'h00003003, mk(0, 0, 0, 32'd0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
    vt.push_back('{32'h123450B7, mk(0, 0, 1, 32'h12345000, ALU_PASS_B, 0, 1, 0, 0, 0, 0, 0, 1, 0)});
    vt.push_back('{32'h00001117, mk(0, 0, 2, 32'h00001000, ALU_ADD, 1, 1, 0, 0, 0, 0, 0, 1, 0)});
    vt.push_back('{32'h000080E7, mk(1, 0, 1, 32'd0, ALU_ADD, 0, 1, 0, 2, 0, 0, 0, 1, 0)});
    vt.push_back('{32'h4030D093, mk(1, 0, 1, 32'h403, ALU_SRA, 0, 1, 0, 0, 0, 0, 5, 1, 0)});
    vt.push_back('{32'h4020D1B3, mk(1, 2, 3, 32'd0, ALU_SRA, 0, 0, 0, 0, 0, 0, 5, 1, 0)});
    vt.push_back('{32'h00000013, mk(0, 0, 0, 32'd0, ALU_ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0)});
    vt.push_back('{32'hFFF30283, mk(6, 0, 5, 32'hFFFFFFFF, ALU_ADD, 0, 1, 0, 0, 1, 0, 0, 1, 0)});
    vt.push_back('{32'h40109093, mk(0, 0, 0, 32'd0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
    vt.push_back('{32'h00000073, mk(0, 0, 0, 32'd0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
    vt.push_back('{32'h0020A063, mk(0, 0, 0, 32'd0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
    bus.flush_i = 1'b0; bus.if_valid_i = 1'b0; bus.ex_ready_i = 1'b0;
    bus.if_pc_i = '0; bus.if_instr_i = '0;
    tick();
    tick();
    chk("reset_valid", bus.ex_valid_o, 1'b0);
    chk("reset_pc", bus.ex_pc_o, RPC);
    chk("reset_payload", got(), '0);
    chk("reset_if_ready", bus.if_ready_o, 1'b1);
    rst = 1'b0;
    bus.ex_ready_i = 1'b1;
    foreach (vt[k]) begin
      bus.if_valid_i = 1'b1;
      bus.if_pc_i = 32'h1000 + 32'(k) * 4;
      bus.if_instr_i = vt[k].instr;
      tick();
      chk($sformatf("vec%0d_valid", k), bus.ex_valid_o, 1'b1);
      chk($sformatf("vec%0d_pc", k), bus.ex_pc_o, 32'h1000 + 32'(k) * 4);
      chk($sformatf("vec%0d_dec", k), got(), vt[k].exp);
    end
    bus.if_pc_i = 32'h2000; bus.if_instr_i = vt[0].instr;
    tick();
    ha = got();
    bus.ex_ready_i = 1'b0; bus.if_pc_i = 32'h2004; bus.if_instr_i = vt[1].instr;
    #1 chk("bp_if_ready_low", bus.if_ready_o, 1'b0);
    repeat (3) begin
      tick();
      chk("bp_hold_valid", bus.ex_valid_o, 1'b1);
      chk("bp_hold_pc", bus.ex_pc_o, 32'h2000);
      chk("bp_hold_dec", got(), ha);
      chk("bp_hold_if_ready", bus.if_ready_o, 1'b0);
    end
    bus.ex_ready_i = 1'b1;
    #1 chk("bp_release_if_ready", bus.if_ready_o, 1'b1);
    tick();
    chk("bp_next_pc", bus.ex_pc_o, 32'h2004);
    chk("bp_next_dec", got(), vt[1].exp);
    bus.if_valid_i = 1'b0;
    tick();
    chk("drain_valid", bus.ex_valid_o, 1'b0);
    bus.if_valid_i = 1'b1; bus.flush_i = 1'b1;
    tick();
    chk("flush_accept_valid", bus.ex_valid_o, 1'b0);
    bus.flush_i = 1'b0;
    tick();
    bus.ex_ready_i = 1'b0; bus.flush_i = 1'b1;
    tick();
    chk("flush_hold_valid", bus.ex_valid_o, 1'b0);
    bus.flush_i = 1'b0; bus.if_valid_i = 1'b0; bus.ex_ready_i = 1'b1;
    tick();
    ev = 1'b0; epc = '0; e_dec = '0;
    repeat (400) begin
      bus.flush_i = $urandom_range(0, 15) == 0;
      bus.if_valid_i = $urandom_range(0, 3) != 0;
      bus.ex_ready_i = $urandom_range(0, 2) != 0;
      bus.if_pc_i = $urandom & 32'hFFFF_FFFC;
      bus.if_instr_i = $urandom;
      if ($urandom_range(0, 10) < 10) bus.if_instr_i[6:0] = ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 2))
        0: bus.if_instr_i[31:25] = 7'h00;
        1: bus.if_instr_i[31:25] = 7'h20;
        default: ;
      endcase
      #1 chk("rnd_if_ready", bus.if_ready_o, !ev || bus.ex_ready_i);
      acc = bus.if_valid_i && (!ev || bus.ex_ready_i);
      tick();
      if (bus.flush_i) ev = 1'b0;
      else if (acc) begin
        ev = 1'b1;
        epc = bus.if_pc_i;
        e_dec = ref_dec(bus.if_instr_i);
      end else if (bus.ex_ready_i) ev = 1'b0;
      chk("rnd_valid", bus.ex_valid_o, ev);
      if (ev) begin
        chk("rnd_pc", bus.ex_pc_o, epc);
        chk($sformatf("rnd_dec_%h", bus.if_instr_i), got(), e_dec);
      end
    end
    bus.flush_i = 1'b0; bus.if_valid_i = 1'b1; bus.ex_ready_i = 1'b1;
    bus.if_pc_i = 32'h3000; bus.if_instr_i = vt[0].instr;
    tick();
    bus.ex_ready_i = 1'b0; bus.if_valid_i = 1'b0;
    tick();
    chk("stall_valid", bus.ex_valid_o, 1'b1);
    #2 rst = 1'b1;
    #1 chk("async_rst_valid", bus.ex_valid_o, 1'b0);
    chk("async_rst_pc", bus.ex_pc_o, RPC);
    #2 rst = 1'b0;
    tick();
    chk("post_rst_valid", bus.ex_valid_o, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
